pwm_deadband: RTL and testbench

PWM_DEADBAND -- requirements
Module: pwm_deadband

---
 rtl/pwm_deadband_if.sv | 10 +
 rtl/pwm_deadband.sv | 174 +++++++++++++++++
 tb/tb_pwm_deadband.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_deadband_if.sv
// Register bus for pwm_deadband: single-cycle writes, combinational read data.
interface pwm_deadband_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, output addr_i, output data_i, input data_o);
  modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/pwm_deadband.sv
// Four-channel complementary PWM driver with per-channel dead-time insertion.
// Define PWM_DEADBAND_POLARITY_EN to enable per-channel output inversion (CTRL[7:4]).
module pwm_deadband (
  input  logic          clk,
  input  logic          rst,
  pwm_deadband_if.slave bus,
  input  logic [3:0]    pwm_i,
  output logic [3:0]    hi_o,
  output logic [3:0]    lo_o
);

  // state  | meaning
  // OFF    | channel disabled, both drives off
  // LO_ON  | low side on
  // DEAD_R | dead time before high side turns on
  // HI_ON  | high side on
  // DEAD_F | dead time before low side turns on
  typedef enum logic [2:0] {S_OFF, S_LO_ON, S_DEAD_R, S_HI_ON, S_DEAD_F} state_t;

  logic [3:0] en_q;
  logic [3:0] pol_q;
  logic [3:0] pwm_q;
  logic [3:0] hi_q;
  logic [3:0] lo_q;
  logic [3:0] dead;
  logic [7:0] dt_q    [4];
  logic [7:0] cnt_q   [4];
  state_t     state_q [4];
  logic       unused_bits;

  assign unused_bits = ^{bus.addr_i[31:8], bus.data_i[31:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q  <= '0;
      pwm_q <= '0;
      for (int n = 0; n < 4; n++) dt_q[n] <= '0;
    end else begin
      pwm_q <= pwm_i;
      if (bus.we_i) begin
        case (bus.addr_i[7:0])
          8'h00:   en_q     <= bus.data_i[3:0];
          8'h04:   dt_q[0]  <= bus.data_i[7:0];
          8'h08:   dt_q[1]  <= bus.data_i[7:0];
          8'h0C:   dt_q[2]  <= bus.data_i[7:0];
          8'h10:   dt_q[3]  <= bus.data_i[7:0];
          default: ;
        endcase
      end
    end
  end

`ifdef PWM_DEADBAND_POLARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pol_q <= '0;
    end else if (bus.we_i && bus.addr_i[7:0] == 8'h00) begin
      pol_q <= bus.data_i[7:4];
    end
  end
`else
  assign pol_q = 4'h0;
`endif

  always_comb begin
    for (int n = 0; n < 4; n++) dead[n] = (state_q[n] == S_DEAD_R) || (state_q[n] == S_DEAD_F);
  end

  always_comb begin
    bus.data_o = '0;
    case (bus.addr_i[7:0])
      8'h00:   bus.data_o[7:0]   = {pol_q, en_q};
      8'h04:   bus.data_o[7:0]   = dt_q[0];
      8'h08:   bus.data_o[7:0]   = dt_q[1];
      8'h0C:   bus.data_o[7:0]   = dt_q[2];
      8'h10:   bus.data_o[7:0]   = dt_q[3];
      8'h14: begin
        bus.data_o[3:0]   = pwm_q;
        bus.data_o[19:16] = dead;
      end
      default: ;
    endcase
  end

  // The dead-time counter is only loaded on entry to a dead state, so DT writes
  // never disturb an interval already running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= S_OFF;
        cnt_q[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (!en_q[n]) begin
          state_q[n] <= S_OFF;
          hi_q[n]    <= 1'b0;
          lo_q[n]    <= 1'b0;
        end else begin
          case (state_q[n])
            S_OFF: begin
              hi_q[n] <= 1'b0;
              if (pwm_q[n]) begin
                state_q[n] <= S_DEAD_R;
                cnt_q[n]   <= dt_q[n];
                lo_q[n]    <= 1'b0;
              end else begin
                state_q[n] <= S_LO_ON;
                lo_q[n]    <= 1'b1;
              end
            end
            S_LO_ON: begin
              if (pwm_q[n]) begin
                lo_q[n] <= 1'b0;
                if (dt_q[n] != 8'd0) begin
                  state_q[n] <= S_DEAD_R;
                  cnt_q[n]   <= dt_q[n];
                end else begin
                  state_q[n] <= S_HI_ON;
                  hi_q[n]    <= 1'b1;
                end
              end
            end
            S_DEAD_R: begin
              if (!pwm_q[n]) begin
                state_q[n] <= S_LO_ON;
                lo_q[n]    <= 1'b1;
              end else if (cnt_q[n] <= 8'd1) begin
                state_q[n] <= S_HI_ON;
                hi_q[n]    <= 1'b1;
              end else begin
                cnt_q[n] <= cnt_q[n] - 8'd1;
              end
            end
            S_HI_ON: begin
              if (!pwm_q[n]) begin
                hi_q[n] <= 1'b0;
                if (dt_q[n] != 8'd0) begin
                  state_q[n] <= S_DEAD_F;
                  cnt_q[n]   <= dt_q[n];
                end else begin
                  state_q[n] <= S_LO_ON;
                  lo_q[n]    <= 1'b1;
                end
              end
            end
            S_DEAD_F: begin
              if (pwm_q[n]) begin
                state_q[n] <= S_HI_ON;
                hi_q[n]    <= 1'b1;
              end else if (cnt_q[n] <= 8'd1) begin
                state_q[n] <= S_LO_ON;
                lo_q[n]    <= 1'b1;
              end else begin
                cnt_q[n] <= cnt_q[n] - 8'd1;
              end
            end
            default: begin
              state_q[n] <= S_OFF;
              hi_q[n]    <= 1'b0;
              lo_q[n]    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign hi_o = hi_q ^ pol_q;
  assign lo_o = lo_q ^ pol_q;

endmodule

// File: tb/tb_pwm_deadband.sv
// Directed self-checking bench for pwm_deadband; expected values are hand-derived
// cycle by cycle from the pwm_i edge (latency 2, DT dead cycles).
module tb_pwm_deadband;
  logic       clk;
  logic       rst;
  logic [3:0] pwm_i;
  logic [3:0] hi_o;
  logic [3:0] lo_o;
  int         passed;
  int         total;

  pwm_deadband_if bus ();

  pwm_deadband dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .pwm_i (pwm_i),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.data_i = d;
    tick;
    bus.we_i   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr_i = a;
    #1;
    d = bus.data_o;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b0;
    #12;
    total++;
    if ({hi_o, lo_o} !== 8'h00) $display("FAIL reset_outputs got=%h exp=00", {hi_o, lo_o});
    else passed++;
    for (int i = 0; i < 6; i++) begin
      rd(i * 4, d);
      total++;
      if (d !== 32'h0) $display("FAIL reset_reg_%0h got=%h exp=0", i * 4, d);
      else passed++;
    end
    @(negedge clk);
    rst = 1'b1;
    tick;
    tick;
    total++;
    if ({hi_o, lo_o} !== 8'h00) $display("FAIL reset_idle_outputs got=%h exp=00", {hi_o, lo_o});
    else passed++;
  endtask

  task automatic test_regs;
    logic [31:0] d;
    wr(32'h0C, 32'h1234_56AB);
    rd(32'h0C, d);
    total++;
    if (d !== 32'h0000_00AB) $display("FAIL regs_dt2 got=%h exp=000000ab", d);
    else passed++;
    rd(32'h10C, d);
    total++;
    if (d !== 32'h0000_00AB) $display("FAIL regs_alias got=%h exp=000000ab", d);
    else passed++;
    wr(32'h10, 32'h5A);
    wr(32'h08, 32'h1C3);
    rd(32'h10, d);
    total++;
    if (d !== 32'h5A) $display("FAIL regs_dt3 got=%h exp=5a", d);
    else passed++;
    rd(32'h08, d);
    total++;
    if (d !== 32'hC3) $display("FAIL regs_dt1 got=%h exp=c3", d);
    else passed++;
    wr(32'h14, 32'hFFFF_FFFF);
    wr(32'h18, 32'hFFFF_FFFF);
    rd(32'h14, d);
    total++;
    if (d !== 32'h0) $display("FAIL regs_status_ro got=%h exp=0", d);
    else passed++;
    rd(32'h18, d);
    total++;
    if (d !== 32'h0) $display("FAIL regs_unmapped got=%h exp=0", d);
    else passed++;
    rd(32'h01, d);
    total++;
    if (d !== 32'h0) $display("FAIL regs_misaligned got=%h exp=0", d);
    else passed++;
    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'h0);
  endtask

  task automatic test_basic;
    logic [31:0] d;
    wr(32'h04, 32'd3);
    wr(32'h00, 32'h1);
    tick;
    tick;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b01) $display("FAIL basic_lo_on got=%b exp=01", {hi_o[0], lo_o[0]});
    else passed++;
    pwm_i[0] = 1'b1;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b01) $display("FAIL basic_rise_lat1 got=%b exp=01", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL basic_dead_r_start got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    rd(32'h14, d);
    total++;
    if (d !== 32'h0001_0001) $display("FAIL basic_status_dead got=%h exp=00010001", d);
    else passed++;
    tick;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL basic_dead_r_end got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b10) $display("FAIL basic_hi_on got=%b exp=10", {hi_o[0], lo_o[0]});
    else passed++;
    rd(32'h14, d);
    total++;
    if (d !== 32'h0000_0001) $display("FAIL basic_status_hi got=%h exp=00000001", d);
    else passed++;
    repeat (5) tick;
    pwm_i[0] = 1'b0;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b10) $display("FAIL basic_fall_lat1 got=%b exp=10", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL basic_dead_f_start got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL basic_dead_f_end got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b01) $display("FAIL basic_lo_back got=%b exp=01", {hi_o[0], lo_o[0]});
    else passed++;
  endtask

  task automatic test_dt_write;
    logic [31:0] d;
    pwm_i[0] = 1'b1;
    tick;
    tick;
    wr(32'h04, 32'd6);
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL dtw_no_reload_dead got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b10) $display("FAIL dtw_no_reload_hi got=%b exp=10", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    tick;
    pwm_i[0] = 1'b0;
    tick;
    wr(32'h04, 32'd2);
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL dtw_same_edge_dead got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    repeat (5) tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL dtw_old_value_dead got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b01) $display("FAIL dtw_old_value_lo got=%b exp=01", {hi_o[0], lo_o[0]});
    else passed++;
    rd(32'h04, d);
    total++;
    if (d !== 32'd2) $display("FAIL dtw_readback got=%h exp=2", d);
    else passed++;
  endtask

  task automatic test_abort;
    logic saw_hi;
    wr(32'h04, 32'd5);
    pwm_i[0] = 1'b1;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b01) $display("FAIL abort_lat1 got=%b exp=01", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    pwm_i[0] = 1'b0;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL abort_dead1 got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL abort_dead2 got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b01) $display("FAIL abort_lo_back got=%b exp=01", {hi_o[0], lo_o[0]});
    else passed++;
    saw_hi = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      saw_hi = saw_hi | hi_o[0];
    end
    total++;
    if (saw_hi !== 1'b0) $display("FAIL abort_hi_never got=%b exp=0", saw_hi);
    else passed++;
  endtask

  task automatic test_dt_zero;
    logic [15:0] pat;
    logic        prev;
    pat = 16'b0011_0110_0101_1100;
    pwm_i[1] = 1'b0;
    wr(32'h08, 32'd0);
    wr(32'h00, 32'h2);
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL dt0_ch0_off got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    total++;
    if ({hi_o[1], lo_o[1]} !== 2'b01) $display("FAIL dt0_ch1_lo got=%b exp=01", {hi_o[1], lo_o[1]});
    else passed++;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pwm_i[1] = pat[i];
      tick;
      total++;
      if ({hi_o[1], lo_o[1]} !== {prev, ~prev})
        $display("FAIL dt0_toggle_%0d got=%b exp=%b", i, {hi_o[1], lo_o[1]}, {prev, ~prev});
      else passed++;
      prev = pat[i];
    end
    pwm_i[1] = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_disable_reset;
    logic [31:0] d;
    wr(32'h04, 32'd4);
    wr(32'h00, 32'h1);
    pwm_i[0] = 1'b1;
    repeat (6) tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b10) $display("FAIL dis_hi_on got=%b exp=10", {hi_o[0], lo_o[0]});
    else passed++;
    wr(32'h00, 32'h0);
    tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b00) $display("FAIL dis_off got=%b exp=00", {hi_o[0], lo_o[0]});
    else passed++;
    wr(32'h00, 32'h1);
    repeat (5) tick;
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b10) $display("FAIL dis_reenable_hi got=%b exp=10", {hi_o[0], lo_o[0]});
    else passed++;
    pwm_i[0] = 1'b0;
    tick;
    tick;
    rd(32'h14, d);
    total++;
    if (d !== 32'h0001_0000) $display("FAIL rst_pre_dead_f got=%h exp=00010000", d);
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({hi_o, lo_o} !== 8'h00) $display("FAIL rst_async_outputs got=%h exp=00", {hi_o, lo_o});
    else passed++;
    rd(32'h14, d);
    total++;
    if (d !== 32'h0) $display("FAIL rst_async_status got=%h exp=0", d);
    else passed++;
    rd(32'h00, d);
    total++;
    if (d !== 32'h0) $display("FAIL rst_async_ctrl got=%h exp=0", d);
    else passed++;
    rd(32'h04, d);
    total++;
    if (d !== 32'h0) $display("FAIL rst_async_dt0 got=%h exp=0", d);
    else passed++;
    tick;
    rst = 1'b1;
    tick;
    tick;
    total++;
    if ({hi_o, lo_o} !== 8'h00) $display("FAIL rst_release_outputs got=%h exp=00", {hi_o, lo_o});
    else passed++;
  endtask

  task automatic test_polarity;
    logic [31:0] d;
    wr(32'h00, 32'h11);
    tick;
    rd(32'h00, d);
`ifdef PWM_DEADBAND_POLARITY_EN
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b10) $display("FAIL pol_inverted got=%b exp=10", {hi_o[0], lo_o[0]});
    else passed++;
    total++;
    if (d !== 32'h11) $display("FAIL pol_ctrl_read got=%h exp=11", d);
    else passed++;
`else
    total++;
    if ({hi_o[0], lo_o[0]} !== 2'b01) $display("FAIL pol_active_high got=%b exp=01", {hi_o[0], lo_o[0]});
    else passed++;
    total++;
    if (d !== 32'h01) $display("FAIL pol_ctrl_read got=%h exp=01", d);
    else passed++;
`endif
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b0;
    pwm_i      = 4'h0;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h0;
    bus.data_i = 32'h0;
    test_reset;
    test_regs;
    test_basic;
    test_dt_write;
    test_abort;
    test_dt_zero;
    test_disable_reset;
    test_polarity;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
